// File: rtl/jt6295_decmix.sv
// Per-channel ADPCM decoder, attenuator and four-slot mixer for the JT6295.
// Channel decoder state lives in a 4-entry rotating ring whose head is the current slot.
module jt6295_decmix #(
  parameter logic [1:0] SLOT0 = 2'd2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cen4,
  input  logic               pipe_en,
  input  logic [3:0]         pipe_att,
  input  logic [3:0]         pipe_data,
  output logic signed [13:0] sound,
  output logic               sample
);

  localparam logic [10:0] STEP [0:48] = '{
    11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,   11'd31,
    11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,   11'd60,   11'd66,
    11'd73,   11'd80,   11'd88,   11'd97,   11'd107,  11'd118,  11'd130,  11'd143,
    11'd157,  11'd173,  11'd190,  11'd209,  11'd230,  11'd253,  11'd279,  11'd307,
    11'd337,  11'd371,  11'd408,  11'd449,  11'd494,  11'd544,  11'd598,  11'd658,
    11'd724,  11'd796,  11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411,
    11'd1552
  };

  localparam logic [5:0] VOL [0:15] = '{
    6'd32, 6'd22, 6'd16, 6'd11, 6'd8, 6'd6, 6'd4, 6'd3,
    6'd2,  6'd0,  6'd0,  6'd0,  6'd0, 6'd0, 6'd0, 6'd0
  };

  logic [1:0]         r_slot;
  logic signed [11:0] r_smp [0:3];
  logic [5:0]         r_idx [0:3];
  logic signed [12:0] r_scaled;
  logic [1:0]         r_bSlot;
  logic signed [13:0] r_acc;

  logic [12:0]        w_step13;
  logic [12:0]        w_diff;
  logic signed [13:0] w_smpExt;
  logic signed [13:0] w_diffExt;
  logic signed [13:0] w_sum;
  logic signed [11:0] w_smpSat;
  logic signed [7:0]  w_adj;
  logic signed [7:0]  w_idxSum;
  logic [5:0]         w_idxSat;
  logic signed [11:0] w_newSmp;
  logic [5:0]         w_newIdx;
  logic signed [17:0] w_smp18;
  logic signed [17:0] w_vol18;
  logic signed [17:0] w_prod;
  logic signed [12:0] w_scaled;
  logic signed [13:0] w_mixIn;
  logic signed [13:0] w_accNext;

  // Decode the head entry of the ring with the current nibble
  always_comb begin
    w_step13  = {2'b00, STEP[r_idx[0]]};
    w_diff    = (w_step13 >> 3)
              + (pipe_data[2] ? w_step13        : 13'd0)
              + (pipe_data[1] ? (w_step13 >> 1) : 13'd0)
              + (pipe_data[0] ? (w_step13 >> 2) : 13'd0);
    w_smpExt  = {{2{r_smp[0][11]}}, r_smp[0]};
    w_diffExt = {1'b0, w_diff};
    w_sum     = pipe_data[3] ? (w_smpExt - w_diffExt) : (w_smpExt + w_diffExt);
    if (w_sum > 14'sd2047)
      w_smpSat = 12'sd2047;
    else if (w_sum < -14'sd2048)
      w_smpSat = -12'sd2048;
    else
      w_smpSat = w_sum[11:0];

    case (pipe_data[2:0])
      3'd4:    w_adj = 8'sd2;
      3'd5:    w_adj = 8'sd4;
      3'd6:    w_adj = 8'sd6;
      3'd7:    w_adj = 8'sd8;
      default: w_adj = -8'sd1;
    endcase
    w_idxSum = $signed({2'b00, r_idx[0]}) + w_adj;
    if (w_idxSum < 8'sd0)
      w_idxSat = 6'd0;
    else if (w_idxSum > 8'sd48)
      w_idxSat = 6'd48;
    else
      w_idxSat = w_idxSum[5:0];

    // An idle slot clears its channel so a restart decodes from zero
    w_newSmp = pipe_en ? w_smpSat : 12'sd0;
    w_newIdx = pipe_en ? w_idxSat : 6'd0;
  end

  // Attenuate: the bit slice of the product is a floor division by 32
  always_comb begin
    w_smp18   = 18'(w_newSmp);
    w_vol18   = $signed({12'd0, VOL[pipe_att]});
    w_prod    = w_smp18 * w_vol18;
    w_scaled  = w_prod[17:5];
    w_mixIn   = 14'(r_scaled);
    w_accNext = (r_bSlot == 2'd0) ? w_mixIn : (r_acc + w_mixIn);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot   <= SLOT0;
      for (int i = 0; i < 4; i++) begin
        r_smp[i] <= 12'sd0;
        r_idx[i] <= 6'd0;
      end
      r_scaled <= 13'sd0;
      r_bSlot  <= 2'd0;
      r_acc    <= 14'sd0;
      sound    <= 14'sd0;
      sample   <= 1'b0;
    end else begin
      sample <= 1'b0;
      if (cen4) begin
        r_slot <= r_slot + 2'd1;
        for (int i = 0; i < 3; i++) begin
          r_smp[i] <= r_smp[i+1];
          r_idx[i] <= r_idx[i+1];
        end
        r_smp[3] <= w_newSmp;
        r_idx[3] <= w_newIdx;
        r_scaled <= w_scaled;
        r_bSlot  <= r_slot;
        r_acc    <= w_accNext;
        // Slot 3 closes the frame one slot after its nibble was decoded
        if (r_bSlot == 2'd3) begin
          sound  <= r_acc + w_mixIn;
          sample <= 1'b1;
        end
      end
    end
  end

endmodule
